change_dispenser: RTL and testbench

- Output-side counterpart of the coin acceptor: pays change back out of the machine, one coin at a time.
- Takes a change amount in the machine's money unit (1 unit = 100; coin values 500/1000/2000/5000 = 5/10/20/50 units).
- Selects coins greedily from an internal per-denomination inventory and hands each coin to the coin-ejector mechanism over a valid/ready handshake.
- Sits after the vending FSM's DISPENSE state; inserted coins can be deposited back into its inventory.

---
 rtl/change_dispenser.sv | 142 ++++++++++++++
 tb/tb_change_dispenser.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy coin change payout with per-denomination inventory
module change_dispenser #(
  parameter int INITIAL_COUNT = 5,
  parameter int MAX_COUNT     = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] change_amount,
  input  logic        deposit_valid,
  input  logic [1:0]  deposit_coin,
  output logic        coin_valid,
  output logic [1:0]  coin_out,
  input  logic        coin_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] remaining,
  output logic [3:0]  count_500,
  output logic [3:0]  count_1000,
  output logic [3:0]  count_2000,
  output logic [3:0]  count_5000
);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_ISSUE, S_DONE, S_FAIL} state_t;

  localparam logic [3:0] INIT_CNT = 4'(INITIAL_COUNT);
  localparam logic [3:0] MAX_CNT  = 4'(MAX_COUNT);

  state_t      state_q, state_d;
  logic [15:0] remaining_q, remaining_d;
  logic        coin_valid_q, coin_valid_d;
  logic [1:0]  coin_out_q, coin_out_d;
  logic [3:0]  count_q [4];
  logic [3:0]  count_d [4];
  logic        accept;
  logic        pick_found;
  logic [1:0]  pick;

  function automatic logic [15:0] coin_value(input logic [1:0] d);
    case (d)
      2'd0:    return 16'd5;
      2'd1:    return 16'd10;
      2'd2:    return 16'd20;
      default: return 16'd50;
    endcase
  endfunction

  assign accept = (state_q == S_ISSUE) && coin_valid_q && coin_ready;

  // Ascending scan: the last qualifying denomination is the largest one.
  always_comb begin
    pick_found = 1'b0;
    pick       = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if ((coin_value(2'(i)) <= remaining_q) && (count_q[i] != 4'd0)) begin
        pick_found = 1'b1;
        pick       = 2'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    coin_valid_d = coin_valid_q;
    coin_out_d   = coin_out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          remaining_d = change_amount;
          state_d     = S_SELECT;
        end
      end
      S_SELECT: begin
        if (remaining_q == 16'd0) begin
          state_d = S_DONE;
        end else if ((remaining_q % 16'd5) != 16'd0) begin
          state_d = S_FAIL;
        end else if (pick_found) begin
          coin_out_d   = pick;
          coin_valid_d = 1'b1;
          state_d      = S_ISSUE;
        end else begin
          state_d = S_FAIL;
        end
      end
      S_ISSUE: begin
        if (accept) begin
          remaining_d  = remaining_q - coin_value(coin_out_q);
          coin_valid_d = 1'b0;
          state_d      = S_SELECT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A same-denomination deposit and ejection on one edge cancel out.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      count_d[i] = count_q[i];
      if (accept && (coin_out_q == 2'(i))) begin
        if (!(deposit_valid && (deposit_coin == 2'(i)))) begin
          count_d[i] = count_q[i] - 4'd1;
        end
      end else if (deposit_valid && (deposit_coin == 2'(i)) && (count_q[i] < MAX_CNT)) begin
        count_d[i] = count_q[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      remaining_q  <= 16'd0;
      coin_valid_q <= 1'b0;
      coin_out_q   <= 2'd0;
      for (int i = 0; i < 4; i++) count_q[i] <= INIT_CNT;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      coin_valid_q <= coin_valid_d;
      coin_out_q   <= coin_out_d;
      for (int i = 0; i < 4; i++) count_q[i] <= count_d[i];
    end
  end

  assign coin_valid = coin_valid_q;
  assign coin_out   = coin_out_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_FAIL);
  assign remaining  = remaining_q;
  assign count_500  = count_q[0];
  assign count_1000 = count_q[1];
  assign count_2000 = count_q[2];
  assign count_5000 = count_q[3];

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - directed self-checking bench for change_dispenser
module tb_change_dispenser;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] change_amount = 16'd0;
  logic        deposit_valid = 1'b0;
  logic [1:0]  deposit_coin = 2'd0;
  logic        coin_ready = 1'b0;
  logic        coin_valid;
  logic [1:0]  coin_out;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] remaining;
  logic [3:0]  count_500;
  logic [3:0]  count_1000;
  logic [3:0]  count_2000;
  logic [3:0]  count_5000;

  int checks = 0;
  int failures = 0;

  logic [1:0] coins [32];
  int ncoins;
  int first_valid;
  int end_k;
  bit done_seen;
  bit err_seen;
  bit busy_k1;

  change_dispenser dut (
    .clock(clock), .reset(reset), .start(start), .change_amount(change_amount),
    .deposit_valid(deposit_valid), .deposit_coin(deposit_coin),
    .coin_valid(coin_valid), .coin_out(coin_out), .coin_ready(coin_ready),
    .busy(busy), .done(done), .error(error), .remaining(remaining),
    .count_500(count_500), .count_1000(count_1000),
    .count_2000(count_2000), .count_5000(count_5000)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_counts(input string tag, input logic [3:0] e);
    chk({tag, "_c500"},  32'(count_500),  32'(e));
    chk({tag, "_c1000"}, 32'(count_1000), 32'(e));
    chk({tag, "_c2000"}, 32'(count_2000), 32'(e));
    chk({tag, "_c5000"}, 32'(count_5000), 32'(e));
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // k counts negedges after the edge that samples start; extra_k injects a stray start.
  task automatic run(input logic [15:0] amt, input int extra_k);
    @(negedge clock);
    start = 1'b1;
    change_amount = amt;
    @(negedge clock);
    start = 1'b0;
    ncoins = 0; first_valid = -1; end_k = -1;
    done_seen = 1'b0; err_seen = 1'b0; busy_k1 = busy;
    for (int k = 1; k < 200 && end_k < 0; k++) begin
      if (k > 1) @(negedge clock);
      if (coin_valid && first_valid < 0) first_valid = k;
      if (coin_valid && coin_ready && ncoins < 32) begin
        coins[ncoins] = coin_out;
        ncoins++;
      end
      if (done) begin done_seen = 1'b1; end_k = k; end
      if (error) begin err_seen = 1'b1; end_k = k; end
      if (k == extra_k) begin start = 1'b1; change_amount = 16'd10; end
      else start = 1'b0;
    end
    start = 1'b0;
    if (end_k < 0) chk("run_timeout", 32'd0, 32'd1);
  endtask

  task automatic start_and_wait_valid(input logic [15:0] amt);
    @(negedge clock);
    start = 1'b1;
    change_amount = amt;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset();
    chk("rst_valid", 32'(coin_valid), 32'd0);
    chk("rst_coin", 32'(coin_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_rem", 32'(remaining), 32'd0);
    chk_counts("rst", 4'd5);

    coin_ready = 1'b1;
    run(16'd85, -1);
    chk("p85_n", ncoins, 4);
    chk("p85_c0", 32'(coins[0]), 32'd3);
    chk("p85_c1", 32'(coins[1]), 32'd2);
    chk("p85_c2", 32'(coins[2]), 32'd1);
    chk("p85_c3", 32'(coins[3]), 32'd0);
    chk("p85_first", first_valid, 2);
    chk("p85_done", 32'(done_seen), 32'd1);
    chk("p85_end", end_k, 10);
    chk("p85_busy", 32'(busy_k1), 32'd1);
    chk("p85_rem", 32'(remaining), 32'd0);
    chk_counts("p85", 4'd4);

    run(16'd0, -1);
    chk("z_done", 32'(done_seen), 32'd1);
    chk("z_end", end_k, 2);
    chk("z_novalid", first_valid, -1);
    chk_counts("z", 4'd4);

    run(16'd7, -1);
    chk("s7_err", 32'(err_seen), 32'd1);
    chk("s7_end", end_k, 2);
    chk("s7_novalid", first_valid, -1);
    chk("s7_rem", 32'(remaining), 32'd7);

    run(16'd85, 3);
    chk("busy_n", ncoins, 4);
    chk("busy_done", 32'(done_seen), 32'd1);
    chk("busy_end", end_k, 10);
    chk("busy_rem", 32'(remaining), 32'd0);
    chk_counts("busy", 4'd3);
    @(negedge clock);
    chk("busy_idle", 32'(busy), 32'd0);

    apply_reset();
    coin_ready = 1'b0;
    start_and_wait_valid(16'd50);
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", 32'(coin_valid), 32'd1);
      chk("bp_coin", 32'(coin_out), 32'd3);
      chk("bp_cnt", 32'(count_5000), 32'd5);
      @(negedge clock);
    end
    coin_ready = 1'b1;
    @(negedge clock);
    chk("bp_cnt_after", 32'(count_5000), 32'd4);
    chk("bp_valid_after", 32'(coin_valid), 32'd0);
    @(negedge clock);
    chk("bp_done", 32'(done), 32'd1);
    chk("bp_rem", 32'(remaining), 32'd0);

    apply_reset();
    run(16'd430, -1);
    chk("ex_n", ncoins, 20);
    for (int i = 0; i < 20 && i < ncoins; i++)
      chk($sformatf("ex_c%0d", i), 32'(coins[i]), 32'(3 - i / 5));
    chk("ex_err", 32'(err_seen), 32'd1);
    chk("ex_rem", 32'(remaining), 32'd5);
    chk_counts("ex", 4'd0);

    apply_reset();
    coin_ready = 1'b0;
    start_and_wait_valid(16'd50);
    chk("sd_valid", 32'(coin_valid), 32'd1);
    coin_ready = 1'b1;
    deposit_valid = 1'b1;
    deposit_coin = 2'd3;
    @(negedge clock);
    deposit_valid = 1'b0;
    chk("sd_cnt", 32'(count_5000), 32'd5);
    chk("sd_valid_after", 32'(coin_valid), 32'd0);
    @(negedge clock);
    chk("sd_done", 32'(done), 32'd1);

    deposit_coin = 2'd0;
    deposit_valid = 1'b1;
    repeat (10) @(negedge clock);
    chk("sat_15", 32'(count_500), 32'd15);
    @(negedge clock);
    chk("sat_hold", 32'(count_500), 32'd15);
    deposit_valid = 1'b0;
    chk("sat_other", 32'(count_1000), 32'd5);

    apply_reset();
    coin_ready = 1'b0;
    start_and_wait_valid(16'd85);
    chk("mr_valid", 32'(coin_valid), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("mr_valid_drop", 32'(coin_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_cnt", 32'(count_5000), 32'd5);
    @(negedge clock);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
